// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : acq_sequencer
// Brief    : Sensor acquisition sequencer. Issues periodic ADC triggers,
//            captures each returned sample and forwards it to a sample FIFO,
//            tracking dropped samples (overrun) and missed conversions
//            (timeout).
// Revision : 1.0 - initial release
// ============================================================================
module acq_sequencer #(
    parameter int NUM_SAMPLES = 1024
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] period_i,
    input  logic [15:0] adc_data_i,
    input  logic        adc_valid_i,
    input  logic        fifo_full_i,
    output logic        adc_trig_o,
    output logic        fifo_wrreq_o,
    output logic [15:0] fifo_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        overrun_o,
    output logic        timeout_o,
    output logic [15:0] sample_count_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_WRITE     = 3'd3,
        S_GAP       = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    // Target count widened by one bit so the incremented count never wraps
    // before it is compared.
    localparam logic [16:0] NUM_SAMPLES_EXT = 17'(NUM_SAMPLES);

    state_t      state_q;
    logic [15:0] period_q;
    logic [15:0] cnt_q;
    logic [15:0] data_q;
    logic [15:0] count_q;
    logic        overrun_q;
    logic        timeout_q;

    logic [15:0] period_d;
    logic [15:0] cnt_dec_d;
    logic [16:0] count_inc_d;

    // Clamped period, saturating counter decrement and incremented sample count.
    always_comb begin
        period_d    = (period_i < 16'd3) ? 16'd3 : period_i;
        cnt_dec_d   = (cnt_q == 16'd0) ? 16'd0 : (cnt_q - 16'd1);
        count_inc_d = {1'b0, count_q} + 17'd1;
    end

    // Sequencer FSM with its period counter, capture register, count and flags.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= S_IDLE;
            period_q  <= 16'd3;
            cnt_q     <= 16'd0;
            data_q    <= 16'd0;
            count_q   <= 16'd0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else if (abort_i) begin
            // Abort drops back to IDLE but leaves count and flags readable.
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        period_q  <= period_d;
                        count_q   <= 16'd0;
                        overrun_q <= 1'b0;
                        timeout_q <= 1'b0;
                        state_q   <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    // Counter hits zero in the last cycle before the next
                    // trigger slot, which lands exactly period cycles later.
                    cnt_q   <= period_q - 16'd2;
                    state_q <= S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    cnt_q <= cnt_dec_d;
                    if (adc_valid_i) begin
                        data_q  <= adc_data_i;
                        state_q <= S_WRITE;
                    end else if (cnt_q == 16'd0) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_WRITE: begin
                    cnt_q   <= cnt_dec_d;
                    count_q <= count_inc_d[15:0];
                    if (fifo_full_i) begin
                        overrun_q <= 1'b1;
                    end
                    if (count_inc_d == NUM_SAMPLES_EXT) begin
                        state_q <= S_DONE;
                    end else if (cnt_q == 16'd0) begin
                        state_q <= S_TRIG;
                    end else begin
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    cnt_q <= cnt_dec_d;
                    if (cnt_q == 16'd0) begin
                        state_q <= S_TRIG;
                    end
                end
                S_DONE: begin
                    cnt_q   <= cnt_dec_d;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are state decodes; the write strobe is additionally qualified
    // by the FIFO full flag in the WRITE cycle itself.
    assign adc_trig_o     = (state_q == S_TRIG);
    assign fifo_wrreq_o   = (state_q == S_WRITE) && !fifo_full_i;
    assign fifo_data_o    = data_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign overrun_o      = overrun_q;
    assign timeout_o      = timeout_q;
    assign sample_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_acq_sequencer
// Brief    : Self-checking bench for acq_sequencer (NUM_SAMPLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;

    logic        clk;
    logic        nRESET;
    logic        start_i;
    logic        abort_i;
    logic [15:0] period_i;
    logic [15:0] adc_data_i;
    logic        adc_valid_i;
    logic        fifo_full_i;
    logic        adc_trig_o;
    logic        fifo_wrreq_o;
    logic [15:0] fifo_data_o;
    logic        busy_o;
    logic        done_o;
    logic        overrun_o;
    logic        timeout_o;
    logic [15:0] sample_count_o;

    int nvec = 0;
    int nerr = 0;

    acq_sequencer #(.NUM_SAMPLES(4)) dut (
        .clk            (clk),
        .nRESET         (nRESET),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .period_i       (period_i),
        .adc_data_i     (adc_data_i),
        .adc_valid_i    (adc_valid_i),
        .fifo_full_i    (fifo_full_i),
        .adc_trig_o     (adc_trig_o),
        .fifo_wrreq_o   (fifo_wrreq_o),
        .fifo_data_o    (fifo_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o),
        .sample_count_o (sample_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [15:0] period;
        logic        valid;
        logic [15:0] data;
        logic        full;
        logic        trig;
        logic        wrreq;
        logic [15:0] fdata;
        logic        busy;
        logic        done;
        logic        ovr;
        logic        tmo;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start_i     = 1'b0;
        abort_i     = 1'b0;
        adc_valid_i = 1'b0;
        fifo_full_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_trig"},  32'(adc_trig_o),     32'd0);
        chk({nm, "_wrreq"}, 32'(fifo_wrreq_o),   32'd0);
        chk({nm, "_fdata"}, 32'(fifo_data_o),    32'd0);
        chk({nm, "_busy"},  32'(busy_o),         32'd0);
        chk({nm, "_done"},  32'(done_o),         32'd0);
        chk({nm, "_ovr"},   32'(overrun_o),      32'd0);
        chk({nm, "_tmo"},   32'(timeout_o),      32'd0);
        chk({nm, "_cnt"},   32'(sample_count_o), 32'd0);
    endtask

    // One acquisition with a responsive sensor model: adc_valid comes dly
    // cycles after every trigger, carrying 0xA000 + trigger number; the FIFO
    // reports full during the WRITE that follows trigger number full_trig.
    task automatic run_acq(input string nm, input logic [15:0] p, input int dly,
                           input int full_trig, input int e_trigs, input int e_spacing,
                           input int e_writes, input logic e_ovr, input logic e_tmo,
                           input int e_cnt, input int e_done_off);
        int cyc, last_trig, first_trig, ntrig, nwr, ndone, done_cyc, post;
        bit fin;
        cyc = 0; last_trig = -1000; first_trig = 0; ntrig = 0; nwr = 0;
        ndone = 0; done_cyc = 0; post = 0; fin = 1'b0;
        @(negedge clk);
        idle_inputs();
        start_i  = 1'b1;
        period_i = p;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            idle_inputs();
            if (adc_trig_o) begin
                if (ntrig > 0) chk({nm, "_spacing"}, cyc - last_trig, e_spacing);
                else first_trig = cyc;
                ntrig++;
                last_trig = cyc;
            end
            if (ntrig > 0 && cyc - last_trig == dly) begin
                adc_valid_i = 1'b1;
                adc_data_i  = 16'(32'hA000 + ntrig);
            end
            if (ntrig == full_trig && cyc - last_trig == dly + 1) fifo_full_i = 1'b1;
            #1;
            if (fifo_wrreq_o) begin
                nwr++;
                chk({nm, "_wrdata"}, 32'(fifo_data_o), 32'hA000 + ntrig);
            end
            if (done_o) begin
                ndone++;
                done_cyc = cyc;
                chk({nm, "_tmo_at_done"}, 32'(timeout_o), 32'(e_tmo));
            end
            if (ndone > 0) post++;
            if (post >= 3) fin = 1'b1;
            cyc++;
        end
        chk({nm, "_finished"}, 32'(fin), 32'd1);
        chk({nm, "_trigs"},  ntrig, e_trigs);
        chk({nm, "_writes"}, nwr, e_writes);
        chk({nm, "_dones"},  ndone, 32'd1);
        chk({nm, "_busy"},   32'(busy_o), 32'd0);
        chk({nm, "_ovr"},    32'(overrun_o), 32'(e_ovr));
        chk({nm, "_tmo"},    32'(timeout_o), 32'(e_tmo));
        chk({nm, "_cnt"},    32'(sample_count_o), e_cnt);
        if (e_done_off >= 0) chk({nm, "_done_offset"}, done_cyc - first_trig, e_done_off);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Period 1 clamps to 3, valid one cycle after each trigger, FIFO full
        // on the third WRITE, then a stray adc_valid in IDLE.
        //            start per  vld data      full trig wr  fdata     busy done ovr tmo cnt
        tbl[0]  = '{1'b1, 16'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 16'd0, 1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00A1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h00A1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 16'd0, 1'b1, 16'h00B2, 1'b0, 1'b0, 1'b0, 16'h00A1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[6]  = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00B2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[7]  = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h00B2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[8]  = '{1'b0, 16'd0, 1'b1, 16'h00C3, 1'b0, 1'b0, 1'b0, 16'h00B2, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[9]  = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h00C3, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        tbl[10] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h00C3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3};
        tbl[11] = '{1'b0, 16'd0, 1'b1, 16'h00D4, 1'b0, 1'b0, 1'b0, 16'h00C3, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3};
        tbl[12] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00D4, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3};
        tbl[13] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h00D4, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        tbl[14] = '{1'b0, 16'd0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 16'h00D4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4};
        tbl[15] = '{1'b0, 16'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h00D4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd4};

        idle_inputs();
        period_i   = 16'd0;
        adc_data_i = 16'd0;
        nRESET     = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        nRESET = 1'b1;

        // Table: clamped period, overrun, count and done behaviour
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle_inputs();
            start_i     = tbl[i].start;
            period_i    = tbl[i].period;
            adc_valid_i = tbl[i].valid;
            adc_data_i  = tbl[i].data;
            fifo_full_i = tbl[i].full;
            #1;
            chk($sformatf("tbl%0d_trig", i),  32'(adc_trig_o),     32'(tbl[i].trig));
            chk($sformatf("tbl%0d_wrreq", i), 32'(fifo_wrreq_o),   32'(tbl[i].wrreq));
            chk($sformatf("tbl%0d_fdata", i), 32'(fifo_data_o),    32'(tbl[i].fdata));
            chk($sformatf("tbl%0d_busy", i),  32'(busy_o),         32'(tbl[i].busy));
            chk($sformatf("tbl%0d_done", i),  32'(done_o),         32'(tbl[i].done));
            chk($sformatf("tbl%0d_ovr", i),   32'(overrun_o),      32'(tbl[i].ovr));
            chk($sformatf("tbl%0d_tmo", i),   32'(timeout_o),      32'(tbl[i].tmo));
            chk($sformatf("tbl%0d_cnt", i),   32'(sample_count_o), 32'(tbl[i].cnt));
        end

        // Nominal run: period 10, sample 2 cycles after trigger
        run_acq("nominal", 16'd10, 2, 0, 4, 10, 4, 1'b0, 1'b0, 4, -1);
        // Second WRITE hits a full FIFO
        run_acq("fullfifo", 16'd10, 2, 2, 4, 10, 3, 1'b1, 1'b0, 4, -1);
        // Silent sensor: window closes in the WAIT_DATA cycle at trig+4,
        // DONE (with timeout visible) follows at trig+5
        run_acq("timeout", 16'd5, 1000, 0, 1, 5, 0, 1'b0, 1'b1, 0, 5);
        // Late sample in the last window cycle stretches spacing to 6
        run_acq("stretch", 16'd5, 4, 0, 4, 6, 4, 1'b0, 1'b0, 4, -1);

        // Abort in GAP after two samples (first one dropped)
        @(negedge clk);
        idle_inputs();
        start_i  = 1'b1;
        period_i = 16'd10;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 2 || c == 12) begin
                adc_valid_i = 1'b1;
                adc_data_i  = 16'(32'hB000 + c);
            end
            if (c == 3) fifo_full_i = 1'b1;
            if (c == 15) abort_i = 1'b1;
            #1;
            if (c == 14) chk("abort_pre_cnt", 32'(sample_count_o), 32'd2);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            chk("abort_busy", 32'(busy_o), 32'd0);
            chk("abort_done", 32'(done_o), 32'd0);
            chk("abort_trig", 32'(adc_trig_o), 32'd0);
            chk("abort_cnt",  32'(sample_count_o), 32'd2);
            chk("abort_ovr",  32'(overrun_o), 32'd1);
        end
        // Restart clears count and flags
        @(negedge clk);
        start_i  = 1'b1;
        period_i = 16'd10;
        @(negedge clk);
        idle_inputs();
        abort_i = 1'b1;
        #1;
        chk("restart_trig", 32'(adc_trig_o), 32'd1);
        chk("restart_cnt",  32'(sample_count_o), 32'd0);
        chk("restart_ovr",  32'(overrun_o), 32'd0);
        // Abort in TRIG
        @(negedge clk);
        idle_inputs();
        #1;
        chk("abort_trig_busy", 32'(busy_o), 32'd0);
        chk("abort_trig_trig", 32'(adc_trig_o), 32'd0);
        // Abort and start together in IDLE
        @(negedge clk);
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("abort_start_busy", 32'(busy_o), 32'd0);
        chk("abort_start_trig", 32'(adc_trig_o), 32'd0);

        // Reset mid-WAIT_DATA; start ignored while busy
        @(negedge clk);
        start_i  = 1'b1;
        period_i = 16'd10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 2) begin
                adc_valid_i = 1'b1;
                adc_data_i  = 16'hC0DE;
            end
            if (c >= 4 && c <= 9) start_i = 1'b1;
            #1;
            chk($sformatf("busyig_trig%0d", c), 32'(adc_trig_o), 32'(c == 0 || c == 10));
        end
        chk("prerst_cnt",   32'(sample_count_o), 32'd1);
        chk("prerst_fdata", 32'(fifo_data_o), 32'hC0DE);
        chk("prerst_busy",  32'(busy_o), 32'd1);
        #2;
        nRESET = 1'b0;
        #1;
        chk_all_zero("asyncrst");
        @(negedge clk);
        nRESET  = 1'b1;
        start_i = 1'b1;
        #1;
        chk("release_busy", 32'(busy_o), 32'd0);
        chk("release_done", 32'(done_o), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("after_release_trig", 32'(adc_trig_o), 32'd1);
        chk("after_release_done", 32'(done_o), 32'd0);
        abort_i = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("final_busy", 32'(busy_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
